v_to_ndc_stream: RTL and testbench
==================================

# v_to_ndc_stream

Streaming world-to-camera vertex transform with ready/valid flow control on both sides. Each accepted vertex has the camera position subtracted, is projected onto the camera basis (u, v, n) by three fixed-point dot products, and is buffered in an output FIFO tagged with its ID. The block sits between the vertex fetch stage and the rasteriser's NDC/perspective stage. It adds two things beyond a free-running transform: lossless backpressure, and safe camera updates between vertices.

## Interface
Parameters:
- C_WIDTH, 18, camera position width (signed).
- P_WIDTH, 16, vertex position width (signed, P_WIDTH ≤ C_WIDTH).
- V_WIDTH, 16, basis vector component width (signed).
- FRAC_BITS, 14, fractional bits of u/v/n.
- ID_WIDTH, 8, vertex tag width.
- DEPTH, 4, output FIFO depth (power of two, ≥ 4).
- NEAR_Z, 0, near-plane threshold in camera-z units (used only with VTN_NEAR_CLIP_EN).

Derived widths:
- PC_W = C_WIDTH+1.
- D_W = PC_W+V_WIDTH−FRAC_BITS+2.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, vertex valid.
- in_ready, out, 1, vertex accepted when in_valid && in_ready.
- in_p, in, 3×P_WIDTH, vertex [x,y,z].
- in_id, in, ID_WIDTH, vertex tag.
- cam_load, in, 1, single-cycle pulse requesting a camera update.
- cam_c, in, 3×C_WIDTH, camera position.
- cam_u, cam_v, cam_n, in, 3×V_WIDTH each, basis vectors.
- cam_busy, out, 1, camera update pending.
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accepts head.
- out_x, out_y, out_z, out, D_W each, signed camera-space coordinates.
- out_id, out, ID_WIDTH, tag of the head entry.
- out_clip, out, 1, near-plane clip flag (only with VTN_NEAR_CLIP_EN).

## Operation
- **Stage 0 (register):** the accepted vertex is sign-extended and PC = P − C is computed using the *active* camera.
- **Stages 1–3:** three parallel dot products. Each result is D = (Σ PC_i·B_i) >>> FRAC_BITS, where >>> is an arithmetic shift (floor). No saturation; D_W is wide enough by construction.
- **Stage 4:** the result is written into the FIFO.
- **Tag and valid:** travel in a 4-deep shift register alongside the data. The pipeline never stalls.
- **Credit rule:** inflight counts vertices in stages 0–3. in_ready = !cam_busy && (fifo_count + inflight < DEPTH). This guarantees FIFO space at write time, so no vertex is ever dropped.
- **Camera FSM, states IDLE → PEND → IDLE:**
  - A cam_load pulse latches cam_* into a shadow register and enters PEND; cam_busy=1.
  - In PEND, in_ready=0. When inflight==0, the shadow is copied to active and the FSM returns to IDLE.
  - cam_load while in PEND overwrites the shadow; the last request wins.
  - If cam_load and a vertex handshake occur in the same cycle, the vertex uses the old camera.
- **FIFO:** a head entry is popped on out_valid && out_ready. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.

## Timing
- **Reset:** all outputs are 0, except in_ready, which is 1 one cycle after rst_n rises.
- **Reset contents:** active and shadow camera = 0; FIFO empty; inflight=0; FSM=IDLE.
- **Reset mid-stream:** all in-flight and buffered vertices are discarded immediately (asynchronous).
- **Latency:** handshake at cycle t → out_valid at t+5, when the FIFO was empty.
- **Throughput:** one vertex per cycle while out_ready=1.
- **Camera swap:** the active camera is updated on the cycle after inflight reaches 0. in_ready can rise again the cycle after that.
- **Full FIFO:** in_ready is low once fifo_count+inflight==DEPTH. It rises one cycle after the pop that frees a slot.

## Configuration
- **VTN_NEAR_CLIP_EN defined:** out_clip is stored per FIFO entry and equals (out_z < NEAR_Z), signed compare, evaluated at stage 4. Clipped vertices are still output; discarding them is the consumer's job.
- **VTN_NEAR_CLIP_EN undefined:** the out_clip port, its FIFO bit and the comparator are absent.

## Test plan
- **Identity camera:** u=(16384,0,0), v=(0,16384,0), n=(0,0,16384), C=0. Push P=(100,−200,300), id=7 → at t+5, out=(100,−200,300), id=7.
- **Translation plus swapped basis:** C=(10,20,30), u=(0,16384,0), v=(16384,0,0), P=(50,60,70) → out_x=40, out_y=40, out_z=40.
- **Backpressure:** DEPTH=4, out_ready=0, in_valid held high with ids 0..5 → exactly 4 accepted and in_ready=0. Then out_ready=1 → ids 0..5 emerge in order with no loss or duplication.
- **Camera swap mid-stream:** stream ids 0..9 and pulse cam_load at id 4's handshake → ids 0–4 use the old camera and ids 5–9 the new one. cam_busy is high until the pipeline drains, with no gap in output ordering.
- **Reset mid-operation:** drop rst_n with 3 vertices in flight and 2 buffered → out_valid=0 immediately. After release, the first new vertex appears at t+5 with the correct value.
- **Near clip (VTN_NEAR_CLIP_EN, NEAR_Z=10):** identity camera, P_z=5 → out_clip=1; P_z=10 → out_clip=0. Rebuilding without the macro removes the port.

Source files
------------

// File: rtl/v_to_ndc_stream_if.sv
`timescale 1ns/1ps
// v_to_ndc_stream_if: vertex-in, camera-control and result-out bundle for v_to_ndc_stream.
// Ports: in_* (vertex ready/valid), cam_* (camera load and busy), out_* (result ready/valid).
// Optional out_clip exists only when VTN_NEAR_CLIP_EN is defined.
interface v_to_ndc_stream_if #(
  parameter int C_WIDTH   = 18,
  parameter int P_WIDTH   = 16,
  parameter int V_WIDTH   = 16,
  parameter int FRAC_BITS = 14,
  parameter int ID_WIDTH  = 8
);
  localparam int D_W = C_WIDTH + 1 + V_WIDTH - FRAC_BITS + 2;

  // Index 0 = x, 1 = y, 2 = z for every 3-vector.
  logic                         in_valid;
  logic                         in_ready;
  logic [2:0][P_WIDTH-1:0]      in_p;
  logic [ID_WIDTH-1:0]          in_id;
  logic                         cam_load;
  logic [2:0][C_WIDTH-1:0]      cam_c;
  logic [2:0][V_WIDTH-1:0]      cam_u;
  logic [2:0][V_WIDTH-1:0]      cam_v;
  logic [2:0][V_WIDTH-1:0]      cam_n;
  logic                         cam_busy;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [D_W-1:0]        out_x;
  logic signed [D_W-1:0]        out_y;
  logic signed [D_W-1:0]        out_z;
  logic [ID_WIDTH-1:0]          out_id;
`ifdef VTN_NEAR_CLIP_EN
  logic                         out_clip;
`endif

  modport slave (
    input  in_valid, in_p, in_id, cam_load, cam_c, cam_u, cam_v, cam_n, out_ready,
    output in_ready, cam_busy, out_valid, out_x, out_y, out_z, out_id
`ifdef VTN_NEAR_CLIP_EN
    , output out_clip
`endif
  );

  modport master (
    output in_valid, in_p, in_id, cam_load, cam_c, cam_u, cam_v, cam_n, out_ready,
    input  in_ready, cam_busy, out_valid, out_x, out_y, out_z, out_id
`ifdef VTN_NEAR_CLIP_EN
    , input out_clip
`endif
  );
endinterface

// File: rtl/v_to_ndc_stream.sv
`timescale 1ns/1ps
// v_to_ndc_stream: world-to-camera vertex transform (P-C projected on u,v,n), buffered in an output FIFO.
// Ports: clk, rst_n (async active-low), bus (v_to_ndc_stream_if.slave). Latency 5 cycles into empty FIFO.
// Backpressure: credit-based in_ready, never drops; camera swaps wait for drain. Macro VTN_NEAR_CLIP_EN adds out_clip.
module v_to_ndc_stream #(
  parameter int C_WIDTH   = 18,
  parameter int P_WIDTH   = 16,
  parameter int V_WIDTH   = 16,
  parameter int FRAC_BITS = 14,
  parameter int ID_WIDTH  = 8,
  parameter int DEPTH     = 4
`ifdef VTN_NEAR_CLIP_EN
  , parameter int NEAR_Z  = 0
`endif
) (
  input logic              clk,
  input logic              rst_n,
  v_to_ndc_stream_if.slave bus
);
  localparam int PC_W = C_WIDTH + 1;
  localparam int D_W  = PC_W + V_WIDTH - FRAC_BITS + 2;
  localparam int PR_W = PC_W + V_WIDTH;
  localparam int S_W  = PR_W + 2;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // Camera: active set feeds the datapath, shadow holds a pending update.
  // Basis index [axis][component], axis 0 = u, 1 = v, 2 = n.
  logic [0:0]                   state_q, state_d;
  logic [2:0][C_WIDTH-1:0]      act_c_q, sh_c_q;
  logic [2:0][2:0][V_WIDTH-1:0] act_b_q, sh_b_q;

  logic       in_ready_q, in_ready_d;
  logic       accept, swap;
  logic [2:0] inflight, inflight_d;

  // Pipeline: bit k of vld_q / id_q belongs to stage k.
  logic [3:0]                vld_q;
  logic [3:0][ID_WIDTH-1:0]  id_q;
  logic signed [PC_W-1:0]    pc_q   [3];
  logic signed [PR_W-1:0]    prod_q [3][3];
  logic signed [S_W-1:0]     sum_q  [3];
  logic signed [D_W-1:0]     d_q    [3];

  // Output FIFO.
  logic signed [D_W-1:0]     mem_x  [DEPTH];
  logic signed [D_W-1:0]     mem_y  [DEPTH];
  logic signed [D_W-1:0]     mem_z  [DEPTH];
  logic [ID_WIDTH-1:0]       mem_id [DEPTH];
  logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      push, pop, fifo_vld;

  assign accept     = bus.in_valid && in_ready_q;
  assign inflight   = 3'($countones(vld_q));
  assign inflight_d = 3'($countones({vld_q[2:0], accept}));
  // A load arriving in the same cycle as the drain keeps us pending so the newest shadow wins.
  assign swap       = (state_q == ST_PEND) && !bus.cam_load && (inflight == 3'd0);

  always_comb begin
    state_d = state_q;
    if (bus.cam_load) begin
      state_d = ST_PEND;
    end else if (swap) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      act_c_q <= '0;
      act_b_q <= '0;
      sh_c_q  <= '0;
      sh_b_q  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.cam_load) begin
        sh_c_q <= bus.cam_c;
        sh_b_q <= {bus.cam_n, bus.cam_v, bus.cam_u};
      end
      if (swap) begin
        act_c_q <= sh_c_q;
        act_b_q <= sh_b_q;
      end
    end
  end

  // in_ready is registered from next-state occupancy, so it equals the credit test on
  // the current state while staying low throughout reset.
  assign push     = vld_q[3];
  assign fifo_vld = (cnt_q != '0);
  assign pop      = fifo_vld && bus.out_ready;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  assign in_ready_d = (state_d == ST_IDLE) &&
                      (((CW+1)'(cnt_d) + (CW+1)'(inflight_d)) < DEPTH_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        pc_q[i]  <= '0;
        sum_q[i] <= '0;
        d_q[i]   <= '0;
        for (int j = 0; j < 3; j++) prod_q[i][j] <= '0;
      end
    end else begin
      vld_q <= {vld_q[2:0], accept};
      id_q  <= {id_q[2:0], bus.in_id};
      for (int i = 0; i < 3; i++) begin
        pc_q[i] <= PC_W'($signed(bus.in_p[i])) - PC_W'($signed(act_c_q[i]));
      end
      for (int a = 0; a < 3; a++) begin
        for (int i = 0; i < 3; i++) begin
          prod_q[a][i] <= PR_W'(pc_q[i]) * PR_W'($signed(act_b_q[a][i]));
        end
        sum_q[a] <= S_W'(prod_q[a][0]) + S_W'(prod_q[a][1]) + S_W'(prod_q[a][2]);
        // Arithmetic shift floors toward -inf; D_W holds the full range, so truncation is exact.
        d_q[a]   <= D_W'(sum_q[a] >>> FRAC_BITS);
      end
    end
  end

`ifdef VTN_NEAR_CLIP_EN
  logic mem_clip [DEPTH];
  logic clip_w;
  assign clip_w = d_q[2] < $signed(D_W'(NEAR_Z));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_x[i]  <= '0;
        mem_y[i]  <= '0;
        mem_z[i]  <= '0;
        mem_id[i] <= '0;
`ifdef VTN_NEAR_CLIP_EN
        mem_clip[i] <= 1'b0;
`endif
      end
    end else begin
      if (push) begin
        mem_x[wr_ptr_q]  <= d_q[0];
        mem_y[wr_ptr_q]  <= d_q[1];
        mem_z[wr_ptr_q]  <= d_q[2];
        mem_id[wr_ptr_q] <= id_q[3];
`ifdef VTN_NEAR_CLIP_EN
        mem_clip[wr_ptr_q] <= clip_w;
`endif
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cam_busy  = (state_q == ST_PEND);
  assign bus.out_valid = fifo_vld;
  assign bus.out_x     = mem_x[rd_ptr_q];
  assign bus.out_y     = mem_y[rd_ptr_q];
  assign bus.out_z     = mem_z[rd_ptr_q];
  assign bus.out_id    = mem_id[rd_ptr_q];
`ifdef VTN_NEAR_CLIP_EN
  assign bus.out_clip  = mem_clip[rd_ptr_q];
`endif
endmodule

// File: tb/tb_v_to_ndc_stream.sv
`timescale 1ns/1ps
// tb_v_to_ndc_stream: directed vectors into v_to_ndc_stream, expected results queued at handshake
// and compared by an independent output monitor.
// Ports: none (top-level bench).
module tb_v_to_ndc_stream;
  localparam int D_W = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  v_to_ndc_stream_if #(.C_WIDTH(18), .P_WIDTH(16), .V_WIDTH(16), .FRAC_BITS(14), .ID_WIDTH(8)) bus ();

  v_to_ndc_stream #(
    .C_WIDTH(18), .P_WIDTH(16), .V_WIDTH(16), .FRAC_BITS(14), .ID_WIDTH(8), .DEPTH(4)
`ifdef VTN_NEAR_CLIP_EN
    , .NEAR_Z(10)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic signed [D_W-1:0] x, y, z;
    logic [7:0]            id;
    logic                  clip;
    bit                    cchk;
    int                    lat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int hs_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [2:0][15:0] v16(input int a, input int b, input int c);
    logic [2:0][15:0] r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c);
    return r;
  endfunction

  function automatic logic [2:0][17:0] v18(input int a, input int b, input int c);
    logic [2:0][17:0] r;
    r[0] = 18'(a); r[1] = 18'(b); r[2] = 18'(c);
    return r;
  endfunction

  function automatic exp_t mk(input int x, input int y, input int z, input int id);
    exp_t r;
    r.x = D_W'(x); r.y = D_W'(y); r.z = D_W'(z); r.id = 8'(id);
    r.clip = 1'b0; r.cchk = 1'b0; r.lat = -1;
    return r;
  endfunction

  // Monitor: compares every popped head against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_id", bus.out_id, -1);
      end else begin
        e = exp_q.pop_front();
        chk("out_id", bus.out_id, e.id);
        chk("out_x", $signed(bus.out_x), e.x);
        chk("out_y", $signed(bus.out_y), e.y);
        chk("out_z", $signed(bus.out_z), e.z);
        if (e.lat >= 0) chk("latency_cycle", cyc, e.lat);
`ifdef VTN_NEAR_CLIP_EN
        if (e.cchk) chk("out_clip", bus.out_clip, e.clip);
`endif
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [2:0][15:0] p, input int id, input exp_t e,
                      input bit lat, input bit cam);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_p     = p;
    bus.in_id    = 8'(id);
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e.lat = lat ? cyc + 5 : -1;
    exp_q.push_back(e);
    if (cam) bus.cam_load = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cam_load = 1'b0;
  endtask

  task automatic wait_cam_idle();
    int n = 0;
    while (bus.cam_busy && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("cam_busy_clear", bus.cam_busy, 0);
  endtask

  task automatic load_cam(input logic [2:0][17:0] c, input logic [2:0][15:0] u,
                          input logic [2:0][15:0] v, input logic [2:0][15:0] nb);
    bus.cam_c = c; bus.cam_u = u; bus.cam_v = v; bus.cam_n = nb;
    bus.cam_load = 1'b1;
    @(posedge clk); #1;
    bus.cam_load = 1'b0;
    chk("cam_busy_set", bus.cam_busy, 1);
    wait_cam_idle();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queue_size", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    exp_t e;
    bus.in_valid = 1'b0; bus.in_p = '0; bus.in_id = '0;
    bus.cam_load = 1'b0; bus.cam_c = '0; bus.cam_u = '0; bus.cam_v = '0; bus.cam_n = '0;
    bus.out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cam_busy", bus.cam_busy, 0);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_out_id", bus.out_id, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", bus.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_release", bus.in_ready, 1);

    // Identity camera, with first-vertex latency.
    load_cam(v18(0, 0, 0), v16(16384, 0, 0), v16(0, 16384, 0), v16(0, 0, 16384));
    send(v16(100, -200, 300), 7, mk(100, -200, 300, 7), 1, 0);
    drain();

    // Extreme P and C: P - C spans the full PC range.
    load_cam(v18(131071, -131072, 0), v16(16384, 0, 0), v16(0, 16384, 0), v16(0, 0, 16384));
    send(v16(-32768, 32767, 0), 8, mk(-163839, 163839, 0, 8), 1, 0);
    drain();

    // Half-scale and negated basis: checks floor rounding of the shift.
    load_cam(v18(0, 0, 0), v16(8192, 0, 0), v16(0, 8192, 0), v16(0, 0, -16384));
    send(v16(-3, 3, 7), 9, mk(-2, 1, -7, 9), 0, 0);
    send(v16(1, -1, -32768), 10, mk(0, -1, 32768, 10), 0, 0);
    drain();

    // Translation plus swapped u/v.
    load_cam(v18(10, 20, 30), v16(0, 16384, 0), v16(16384, 0, 0), v16(0, 0, 16384));
    send(v16(50, 60, 70), 11, mk(40, 40, 40, 11), 1, 0);
    drain();

    // Backpressure: only DEPTH vertices may be accepted while the consumer stalls.
    bus.out_ready = 1'b0;
    hs0 = hs_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(v16(i, 2 * i, 3 * i), i, mk(2 * i - 20, i - 10, 3 * i - 30, i), 0, 0);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_accepted", hs_cnt - hs0, 4);
        chk("bp_in_ready_low", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Camera swap requested on id 24's handshake: ids 20..24 old camera, 25..29 identity.
    bus.cam_c = v18(0, 0, 0);
    bus.cam_u = v16(16384, 0, 0); bus.cam_v = v16(0, 16384, 0); bus.cam_n = v16(0, 0, 16384);
    for (int i = 0; i < 10; i++) begin
      if (i < 5) e = mk(-i - 20, 10 * i - 10, i + 70, 20 + i);
      else       e = mk(10 * i, -i, i + 100, 20 + i);
      send(v16(10 * i, -i, i + 100), 20 + i, e, 0, (i == 4));
      if (i == 4) chk("swap_cam_busy_set", bus.cam_busy, 1);
    end
    chk("swap_cam_busy_after", bus.cam_busy, 0);
    drain();

    // Reset with vertices both buffered and in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(v16(i, i, i), 40 + i, mk(i, i, i, 40 + i), 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", bus.out_valid, 0);
    chk("mid_reset_in_ready", bus.in_ready, 0);
    chk("mid_reset_cam_busy", bus.cam_busy, 0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_in_ready", bus.in_ready, 1);
    load_cam(v18(0, 0, 0), v16(16384, 0, 0), v16(0, 16384, 0), v16(0, 0, 16384));
    send(v16(-7, 8, -9), 50, mk(-7, 8, -9, 50), 1, 0);
    drain();

`ifdef VTN_NEAR_CLIP_EN
    e = mk(1, 2, 5, 60);  e.clip = 1'b1; e.cchk = 1'b1;
    send(v16(1, 2, 5), 60, e, 0, 0);
    e = mk(1, 2, 10, 61); e.clip = 1'b0; e.cchk = 1'b1;
    send(v16(1, 2, 10), 61, e, 0, 0);
    drain();
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", bus.out_valid, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
